// File: rtl/sync_hs_pkg.sv
// Shared types and defaults for the req/ack CDC handshake endpoints.
package sync_hs_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2
    } hs_state_e;

    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_ff_chain.sv
// Single-bit multi-flop synchronizer; async active-low reset clears every stage.
module sync_ff_chain
    import sync_hs_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sync_hs_tx.sv
// Source side of a 4-phase req/ack CDC handshake with a one-word pending slot.
//   state  | meaning
//   S_IDLE | nothing in flight; launch when ack_s is low and a word is available
//   S_REQ  | xfer_req high, waiting for synchronized ack to rise
//   S_REL  | xfer_req low, waiting for synchronized ack to fall
module sync_hs_tx
    import sync_hs_pkg::*;
#(
    parameter int W           = 32,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     xfer_data,
    output logic             xfer_req,
    input  logic             xfer_ack,
    output logic             xfer_done,
    output logic             busy,
    output logic [CNT_W-1:0] ovr_cnt
);

    hs_state_e        state_q, state_d;
    logic [W-1:0]     data_q, data_d;
    logic [W-1:0]     pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic [CNT_W-1:0] ovr_q, ovr_d;
    logic             req_q, req_d;
    logic             ack_s;
    logic             launch;
    logic             from_pend;
    logic             pend_wr;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (xfer_ack),
        .q     (ack_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!ack_s && (pend_full_q || in_valid)) state_d = S_REQ;
            S_REQ:  if (ack_s) state_d = S_REL;
            S_REL:  if (!ack_s) state_d = pend_full_q ? S_REQ : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        xfer_done = (state_q == S_REL) && !ack_s;
        busy      = (state_q != S_IDLE);
        in_ready  = !pend_full_q;
        xfer_req  = req_q;
        xfer_data = data_q;
        ovr_cnt   = ovr_q;
    end

    // A launch drains the pending slot first; a same-cycle in_valid then refills it without counting as overwrite.
    always_comb begin
        launch      = (state_d == S_REQ) && (state_q != S_REQ);
        from_pend   = launch && pend_full_q;
        pend_wr     = in_valid && !(launch && !pend_full_q);
        data_d      = data_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q && !from_pend;
        ovr_d       = ovr_q;
        req_d       = (state_d == S_REQ);
        if (launch) begin
            data_d = pend_full_q ? pend_q : in_data;
        end
        if (pend_wr) begin
            pend_d      = in_data;
            pend_full_d = 1'b1;
            if (pend_full_q && !from_pend && (ovr_q != {CNT_W{1'b1}})) begin
                ovr_d = ovr_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            ovr_q       <= '0;
            req_q       <= 1'b0;
        end else begin
            data_q      <= data_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            ovr_q       <= ovr_d;
            req_q       <= req_d;
        end
    end

endmodule

// File: tb/tb_sync_hs_tx.sv
// Self-checking bench for sync_hs_tx: directed scenarios plus randomized traffic against a queue-based model.
module tb_sync_hs_tx;

    localparam int W       = 32;
    localparam int SYNC    = 2;
    localparam int CNT_W   = 2;
    localparam int OVR_MAX = (1 << CNT_W) - 1;
    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_REL  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     xfer_data;
    logic             xfer_req;
    logic             xfer_ack;
    logic             xfer_done;
    logic             busy;
    logic [CNT_W-1:0] ovr_cnt;

    sync_hs_tx #(.W(W), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .xfer_data (xfer_data),
        .xfer_req  (xfer_req),
        .xfer_ack  (xfer_ack),
        .xfer_done (xfer_done),
        .busy      (busy),
        .ovr_cnt   (ovr_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    int           m_phase;
    logic [W-1:0] m_data;
    logic [W-1:0] m_pend[$];
    int           m_ovr;
    bit           m_ack_hist[SYNC];
    logic [W-1:0] exp_q[$];

    // far-end responder and logs
    bit           rsp_hold;
    bit           rsp_rand;
    int           rsp_delay;
    bit           rsp_armed;
    int           rsp_cnt;
    logic [W-1:0] rx_log[$];
    int           done_seen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_data  = '0;
        m_pend.delete();
        m_ovr   = 0;
        for (int i = 0; i < SYNC; i++) m_ack_hist[i] = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit           acks;
        bit           v;
        logic [W-1:0] d;
        acks = m_ack_hist[SYNC-1];
        v    = in_valid;
        d    = in_data;
        case (m_phase)
            PH_IDLE: if (!acks && (m_pend.size() > 0 || v)) begin
                if (m_pend.size() > 0) begin
                    m_data = m_pend.pop_front();
                end else begin
                    m_data = d;
                    v      = 1'b0;
                end
                exp_q.push_back(m_data);
                m_phase = PH_REQ;
            end
            PH_REQ: if (acks) m_phase = PH_REL;
            default: if (!acks) begin
                if (m_pend.size() > 0) begin
                    m_data = m_pend.pop_front();
                    exp_q.push_back(m_data);
                    m_phase = PH_REQ;
                end else begin
                    m_phase = PH_IDLE;
                end
            end
        endcase
        if (v) begin
            if (m_pend.size() > 0) begin
                m_pend.delete();
                if (m_ovr < OVR_MAX) m_ovr++;
            end
            m_pend.push_back(d);
        end
        for (int i = SYNC - 1; i > 0; i--) m_ack_hist[i] = m_ack_hist[i-1];
        m_ack_hist[0] = xfer_ack;
    endtask

    task automatic compare_outputs();
        chk("xfer_req",  xfer_req,  m_phase == PH_REQ);
        chk("xfer_data", xfer_data, m_data);
        chk("xfer_done", xfer_done, (m_phase == PH_REL) && !m_ack_hist[SYNC-1]);
        chk("busy",      busy,      m_phase != PH_IDLE);
        chk("in_ready",  in_ready,  m_pend.size() == 0);
        chk("ovr_cnt",   ovr_cnt,   m_ovr);
    endtask

    // Receiver stand-in: follows xfer_req with a delay and captures xfer_data when it raises ack.
    task automatic responder();
        if (rsp_hold) return;
        if (xfer_req != xfer_ack) begin
            if (!rsp_armed) begin
                rsp_armed = 1'b1;
                rsp_cnt   = rsp_rand ? int'($urandom_range(0, 3)) : rsp_delay;
            end
            if (rsp_cnt == 0) begin
                rsp_armed = 1'b0;
                xfer_ack  = xfer_req;
                if (xfer_req) begin
                    rx_log.push_back(xfer_data);
                    if (exp_q.size() > 0) chk("rx_word", xfer_data, exp_q.pop_front());
                    else chk("rx_unexpected", 1'b1, 1'b0);
                end
            end else begin
                rsp_cnt--;
            end
        end else begin
            rsp_armed = 1'b0;
        end
    endtask

    task automatic cycle(input bit v, input logic [W-1:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        compare_outputs();
        if (xfer_done) done_seen++;
        responder();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        rsp_armed = 1'b0;
        if (!rsp_hold) xfer_ack = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_log();
        rx_log.delete();
        done_seen = 0;
    endtask

    task automatic wait_quiet();
        bit quiet;
        quiet = 1'b0;
        for (int i = 0; i < 300 && !quiet; i++) begin
            cycle(1'b0, '0);
            quiet = (m_phase == PH_IDLE) && (m_pend.size() == 0) && !busy && !xfer_ack;
        end
        if (!quiet) chk("quiet_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        xfer_ack  = 1'b0;
        rsp_hold  = 1'b0;
        rsp_rand  = 1'b0;
        rsp_delay = 5;
        rsp_armed = 1'b0;
        rsp_cnt   = 0;
        done_seen = 0;
        model_reset();

        do_reset();

        // single word
        clear_log();
        cycle(1'b1, 32'hDEADBEEF);
        chk("s1_req_next", xfer_req, 1'b1);
        wait_quiet();
        chk("s1_rx_n", rx_log.size(), 1);
        if (rx_log.size() > 0) chk("s1_rx0", rx_log[0], 32'hDEADBEEF);
        chk("s1_done_n", done_seen, 1);

        // back-to-back
        clear_log();
        cycle(1'b1, 32'hA1);
        cycle(1'b0, '0);
        cycle(1'b1, 32'hA2);
        chk("s2_in_ready", in_ready, 1'b0);
        wait_quiet();
        chk("s2_rx_n", rx_log.size(), 2);
        if (rx_log.size() > 1) begin
            chk("s2_rx0", rx_log[0], 32'hA1);
            chk("s2_rx1", rx_log[1], 32'hA2);
        end
        chk("s2_ovr", ovr_cnt, 0);
        chk("s2_done_n", done_seen, 2);

        // overwrite while in flight
        clear_log();
        cycle(1'b1, 32'hB1);
        cycle(1'b1, 32'hB2);
        cycle(1'b1, 32'hB3);
        cycle(1'b1, 32'hB4);
        chk("s3_ovr", ovr_cnt, 2);
        wait_quiet();
        chk("s3_rx_n", rx_log.size(), 2);
        if (rx_log.size() > 1) begin
            chk("s3_rx0", rx_log[0], 32'hB1);
            chk("s3_rx1", rx_log[1], 32'hB4);
        end

        // saturation: five overwrites on a 2-bit counter
        do_reset();
        clear_log();
        rsp_delay = 10;
        for (int i = 0; i < 7; i++) cycle(1'b1, 32'hE0 + i);
        chk("s4_ovr_sat", ovr_cnt, 3);
        wait_quiet();
        chk("s4_rx_n", rx_log.size(), 2);
        if (rx_log.size() > 1) chk("s4_rx1", rx_log[1], 32'hE6);
        rsp_delay = 5;

        // stale ack held across reset release
        rsp_hold = 1'b1;
        xfer_ack = 1'b1;
        do_reset();
        clear_log();
        repeat (3) cycle(1'b0, '0);
        cycle(1'b1, 32'hC1);
        repeat (3) begin
            cycle(1'b0, '0);
            chk("s5_no_req", xfer_req, 1'b0);
        end
        xfer_ack = 1'b0;
        rsp_hold = 1'b0;
        wait_quiet();
        chk("s5_rx_n", rx_log.size(), 1);
        if (rx_log.size() > 0) chk("s5_rx0", rx_log[0], 32'hC1);

        // reset while in REQ
        do_reset();
        rsp_delay = 10;
        cycle(1'b1, 32'hD1);
        cycle(1'b1, 32'hD2);
        cycle(1'b1, 32'hD3);
        cycle(1'b0, '0);
        chk("s6_pre_req", xfer_req, 1'b1);
        chk("s6_pre_ovr", ovr_cnt, 1);
        rst_n = 1'b0;
        #1;
        chk("s6_req_drop", xfer_req, 1'b0);
        chk("s6_ready", in_ready, 1'b1);
        chk("s6_ovr_clr", ovr_cnt, 0);
        chk("s6_busy", busy, 1'b0);
        chk("s6_data", xfer_data, 0);
        xfer_ack  = 1'b0;
        rsp_armed = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle(1'b0, '0);
        chk("s6_idle_after", busy, 1'b0);
        rsp_delay = 5;

        // randomized traffic
        clear_log();
        rsp_rand = 1'b1;
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 2) == 0, $urandom);
        end
        wait_quiet();
        chk("rand_leftover", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
